// File: rtl/compare_pkg.sv
// Shared definitions for the comparator sweep self-test engine.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package compare_pkg;

  // Bit positions inside the comparator's one-hot result.
  localparam int Y_GT = 2;
  localparam int Y_EQ = 1;
  localparam int Y_LT = 0;

  // Width of the settle-wait counter; covers SETTLE values 0..15.
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/compare_ref_model.sv
// Golden magnitude comparator: produces the expected one-hot {gt, eq, lt} for a and b.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module compare_ref_model
  import compare_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       y
);

  // Exactly one of the three relations holds for any operand pair.
  always_comb begin
    y       = 3'b000;
    y[Y_GT] = (a > b);
    y[Y_EQ] = (a == b);
    y[Y_LT] = (a < b);
  end

endmodule

// File: rtl/compare_sweep_checker.sv
// Exhaustive (a, b) sweep of an external comparator, checking y against the reference model.
// Latency: SETTLE+2 cycles per pair, 2^(2*WIDTH)*(SETTLE+2) cycles per sweep.
// Backpressure: none; start is ignored while busy. COMPARE_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module compare_sweep_checker
  import compare_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  input  logic [2:0]         y,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  localparam logic [WIDTH-1:0] OPND_MAX    = '1;
  localparam logic [2*WIDTH:0] ERR_MAX     = '1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = (SETTLE > 0) ? CNT_W'(SETTLE - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic [2:0]       exp_y;
  logic             mismatch;
  logic             last_pair;
  logic             stop_now;
  logic [2*WIDTH:0] err_next;

  compare_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a (a),
    .b (b),
    .y (exp_y)
  );

  // Any y other than the expected one-hot code (including 000/111) is a mismatch.
  always_comb begin
    mismatch  = (y != exp_y);
    last_pair = (a == OPND_MAX) && (b == OPND_MAX);
    err_next  = err_count;
    if (mismatch && (err_count != ERR_MAX)) begin
      err_next = err_count + (2*WIDTH+1)'(1);
    end
`ifdef COMPARE_SWEEP_STOP_ON_FAIL_EN
    stop_now = mismatch;
`else
    stop_now = 1'b0;
`endif
  end

  // Sweep sequencer: operands only move on the CHECK->DRIVE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      a          <= '0;
      b          <= '0;
      err_count  <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_FINISH: begin
          if (start) begin
            state     <= ST_DRIVE;
            a         <= '0;
            b         <= '0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        ST_DRIVE: begin
          settle_cnt <= '0;
          state      <= (SETTLE > 0) ? ST_WAIT : ST_CHECK;
        end
        ST_WAIT: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          err_count <= err_next;
          // err_count still zero means this is the first failing pair.
          if (mismatch && (err_count == '0)) begin
            fail_a <= a;
            fail_b <= b;
          end
          if (last_pair || stop_now) begin
            state <= ST_FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state <= ST_DRIVE;
            if (b == OPND_MAX) begin
              b <= '0;
              a <= a + WIDTH'(1);
            end else begin
              b <= b + WIDTH'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compare_sweep_checker.sv
// Scoreboard bench: a configurable comparator model answers the sweep, expected results are queued per start.
// Latency: expected sweep length is 256*(SETTLE+2) cycles, shorter when stopping on the first failure.
// Backpressure: not applicable; the bench never stalls the DUT.
module tb_compare_sweep_checker;

  localparam int W     = 4;
  localparam int NP    = 1 << (2*W);
  localparam int PAIRC = 3;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [2:0]       y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [2*W:0]     err_count;
  logic [W-1:0]     fail_a;
  logic [W-1:0]     fail_b;

  compare_sweep_checker #(.WIDTH(W), .SETTLE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_a    (fail_a),
    .fail_b    (fail_b)
  );

  typedef struct {
    int err;
    int fa;
    int fb;
    int pass;
    int cyc;
    int ea;
    int eb;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Comparator environment: mode 0 correct, 1 eq stuck low, 2 single fault at (10,12),
  // 3 output stuck at 010, 4 random injection table.
  int       mode    = 0;
  int       env_gen = 0;
  bit       inj_en  [NP];
  bit [2:0] inj_val [NP];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ideal(int x, int z);
    ideal = {(x > z), (x == z), (x < z)};
  endfunction

  function automatic logic [2:0] env_y(int m, int x, int z);
    logic [2:0] r;
    r = ideal(x, z);
    case (m)
      1: r = r & 3'b101;
      2: if (x == 10 && z == 12) r = 3'b100;
      3: r = 3'b010;
      4: if (inj_en[x*16+z]) r = inj_val[x*16+z];
      default: ;
    endcase
    return r;
  endfunction

  always @(a or b or mode or env_gen) y = env_y(mode, int'(a), int'(b));

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Walk the whole sweep order with plain loops and derive the result the sweep must report.
  task automatic push_expect();
    exp_t e;
    int cnt = 0;
    int first = -1;
    for (int k = 0; k < NP; k++) begin
      if (env_y(mode, k / 16, k % 16) != ideal(k / 16, k % 16)) begin
        if (first < 0) first = k;
        cnt++;
      end
    end
    e.fa = (first < 0) ? 0 : first / 16;
    e.fb = (first < 0) ? 0 : first % 16;
`ifdef COMPARE_SWEEP_STOP_ON_FAIL_EN
    e.err  = (cnt > 0) ? 1 : 0;
    e.cyc  = (first < 0) ? NP * PAIRC : (first + 1) * PAIRC;
    e.ea   = (first < 0) ? 15 : e.fa;
    e.eb   = (first < 0) ? 15 : e.fb;
`else
    e.err  = cnt;
    e.cyc  = NP * PAIRC;
    e.ea   = 15;
    e.eb   = 15;
`endif
    e.pass = (cnt == 0) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_sweep();
    push_expect();
    pulse_start();
  endtask

  task automatic wait_empty(string name);
    for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge clk);
    chk(name, q.size(), 0);
    q.delete();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_a"}, int'(a), 0);
    chk({tag, "_b"}, int'(b), 0);
    chk({tag, "_err"}, int'(err_count), 0);
    chk({tag, "_fail_a"}, int'(fail_a), 0);
    chk({tag, "_fail_b"}, int'(fail_b), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
  endtask

  // Monitor: measures busy duration and checks the final status whenever done rises.
  int busy_cnt = 0;
  bit done_q   = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      done_q   = 1'b0;
    end else begin
      exp_t e;
      if (busy) busy_cnt++;
      if (busy && done) chk("busy_done_overlap", 1, 0);
      if (done && !done_q) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("err_count", int'(err_count), e.err);
          chk("fail_a", int'(fail_a), e.fa);
          chk("fail_b", int'(fail_b), e.fb);
          chk("pass", int'(pass), e.pass);
          chk("sweep_cycles", busy_cnt, e.cyc);
          chk("final_a", int'(a), e.ea);
          chk("final_b", int'(b), e.eb);
        end
        busy_cnt = 0;
      end
      done_q = done;
    end
  end

  initial begin
    start = 1'b0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    mode = 0; run_sweep(); wait_empty("timeout_good");
    mode = 1; run_sweep(); wait_empty("timeout_eq_stuck");
    mode = 2; run_sweep(); wait_empty("timeout_single_fault");

    // Reset in the middle of a sweep, then a clean full sweep.
    mode = 1;
    pulse_start();
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_zero("midreset");
    @(negedge clk) rst_n = 1'b1;
    mode = 0; run_sweep(); wait_empty("timeout_after_reset");

    // Extra start pulses while busy must not disturb the sweep.
    mode = 2;
    run_sweep();
    repeat (4) @(negedge clk);
    pulse_start();
    repeat (93) @(negedge clk);
    pulse_start();
    wait_empty("timeout_double_start");

    mode = 3; run_sweep(); wait_empty("timeout_stuck_010");

    // Random fault tables; the injected code may happen to be correct.
    for (int t = 0; t < 4; t++) begin
      int n;
      for (int k = 0; k < NP; k++) begin
        inj_en[k]  = 1'b0;
        inj_val[k] = 3'b000;
      end
      n = $urandom_range(0, 6);
      for (int j = 0; j < n; j++) begin
        int k;
        k = $urandom_range(0, NP - 1);
        inj_en[k]  = 1'b1;
        inj_val[k] = 3'($urandom_range(0, 7));
      end
      mode = 4;
      env_gen++;
      run_sweep();
      wait_empty("timeout_random");
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
